// File: rtl/uart_frame_pkg.sv
// Shared types and default parameters for the UART frame decoder.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      S_SYNC,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_HOLD
   } state_e;

   localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;
   localparam int unsigned MAX_PAYLOAD_DEF  = 16;
   localparam int unsigned TIMEOUT_CLKS_DEF = 4160;

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload buffer: single write port, registered read port; out-of-range reads return zero.
module uart_frame_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          i_Clock,
   input  logic          i_Reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [7:0]    rd_addr,
   output logic [7:0]    rd_data
);

   localparam logic [8:0] DepthW = 9'(DEPTH);

   logic [7:0] mem [DEPTH];
   logic [7:0] rd_data_q;

   always_ff @(posedge i_Clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Only the output register is reset; the array itself keeps its contents.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rd_data_q <= 8'h00;
      end else if ({1'b0, rd_addr} < DepthW) begin
         rd_data_q <= mem[rd_addr[AW-1:0]];
      end else begin
         rd_data_q <= 8'h00;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-hunting frame decoder (SYNC CMD LEN payload CSUM) with held-frame handshake.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD  = MAX_PAYLOAD_DEF,
   parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Frame_Valid,
   input  logic       i_Frame_Ack,
   output logic [7:0] o_Frame_Cmd,
   output logic [7:0] o_Frame_Len,
   input  logic [7:0] i_Rd_Addr,
   output logic [7:0] o_Rd_Data,
   output logic       o_Err_Checksum,
   output logic       o_Err_Length,
   output logic       o_Err_Timeout,
   output logic       o_Err_Overrun
);

   localparam int unsigned IdxW   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [7:0]  MaxLen = 8'(MAX_PAYLOAD);

   state_e          state_q, state_d;
   logic [7:0]      cmd_q, cmd_d, len_q, len_d, csum_q, csum_d;
   logic [7:0]      frame_cmd_q, frame_cmd_d, frame_len_q, frame_len_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      idx_ext;
   logic            err_csum_d, err_len_d, err_ovr_d;
   logic            err_csum_q, err_len_q, err_ovr_q;
   logic            buf_we;
   logic            tmo_hit;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int unsigned       TmoW    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TmoW-1:0]   TmoLast = TmoW'(TIMEOUT_CLKS - 1);
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            counting, err_tmo_q;

   assign counting = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CSUM);

   // A strobe in the expiry cycle clears the counter, so the byte wins.
   always_comb begin
      tmo_d   = tmo_q;
      tmo_hit = 1'b0;
      if (i_Rx_DV || !counting) begin
         tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
         tmo_hit = 1'b1;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + TmoW'(1);
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         tmo_q     <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         err_tmo_q <= tmo_hit;
      end
   end

   assign o_Err_Timeout = err_tmo_q;
`else
   assign tmo_hit       = 1'b0;
   assign o_Err_Timeout = 1'b0;
`endif

   always_comb begin
      idx_ext           = 8'h00;
      idx_ext[IdxW-1:0] = idx_q;
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      csum_d      = csum_q;
      idx_d       = idx_q;
      frame_cmd_d = frame_cmd_q;
      frame_len_d = frame_len_q;
      err_csum_d  = 1'b0;
      err_len_d   = 1'b0;
      err_ovr_d   = 1'b0;
      buf_we      = 1'b0;

      if (i_Rx_DV) begin
         unique case (state_q)
            S_SYNC: begin
               if (i_Rx_Byte == SYNC_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
               cmd_d   = i_Rx_Byte;
               csum_d  = i_Rx_Byte;
               state_d = S_LEN;
            end
            S_LEN: begin
               len_d  = i_Rx_Byte;
               csum_d = csum_q ^ i_Rx_Byte;
               idx_d  = '0;
               if (i_Rx_Byte > MaxLen) begin
                  err_len_d = 1'b1;
                  state_d   = S_SYNC;
               end else if (i_Rx_Byte == 8'h00) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               buf_we = 1'b1;
               csum_d = csum_q ^ i_Rx_Byte;
               idx_d  = idx_q + IdxW'(1);
               if (idx_ext == len_q - 8'd1) state_d = S_CSUM;
            end
            S_CSUM: begin
               if (i_Rx_Byte == csum_q) begin
                  frame_cmd_d = cmd_q;
                  frame_len_d = len_q;
                  state_d     = S_HOLD;
               end else begin
                  err_csum_d = 1'b1;
                  state_d    = S_SYNC;
               end
            end
            S_HOLD: err_ovr_d = 1'b1;
            default: state_d = S_SYNC;
         endcase
      end else if (tmo_hit) begin
         state_d = S_SYNC;
      end

      if ((state_q == S_HOLD) && i_Frame_Ack) state_d = S_SYNC;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= S_SYNC;
         cmd_q       <= 8'h00;
         len_q       <= 8'h00;
         csum_q      <= 8'h00;
         idx_q       <= '0;
         frame_cmd_q <= 8'h00;
         frame_len_q <= 8'h00;
         err_csum_q  <= 1'b0;
         err_len_q   <= 1'b0;
         err_ovr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         csum_q      <= csum_d;
         idx_q       <= idx_d;
         frame_cmd_q <= frame_cmd_d;
         frame_len_q <= frame_len_d;
         err_csum_q  <= err_csum_d;
         err_len_q   <= err_len_d;
         err_ovr_q   <= err_ovr_d;
      end
   end

   uart_frame_buf #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (IdxW)
   ) u_buf (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .wr_en   (buf_we),
      .wr_addr (idx_q),
      .wr_data (i_Rx_Byte),
      .rd_addr (i_Rd_Addr),
      .rd_data (o_Rd_Data)
   );

   assign o_Frame_Valid  = (state_q == S_HOLD);
   assign o_Frame_Cmd    = frame_cmd_q;
   assign o_Frame_Len    = frame_len_q;
   assign o_Err_Checksum = err_csum_q;
   assign o_Err_Length   = err_len_q;
   assign o_Err_Overrun  = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx; honours UART_FRAME_TIMEOUT_EN when defined.
module tb_uart_frame_rx;

   localparam int unsigned MAXP = 16;
   localparam int unsigned TMO  = 4160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       ack = 1'b0;
   logic [7:0] rd_addr = 8'h00;
   logic       frame_valid, err_csum, err_len, err_tmo, err_ovr;
   logic [7:0] frame_cmd, frame_len, rd_data;

   int checks = 0;
   int failures = 0;
   int n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

   logic [7:0] tx_q [$];
   logic [7:0] exp_pay [0:255];
   logic [7:0] exp_cmd, exp_len;

   always #5 clk = ~clk;

   uart_frame_rx #(
      .MAX_PAYLOAD  (MAXP),
      .TIMEOUT_CLKS (TMO),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Rx_DV        (rx_dv),
      .i_Rx_Byte      (rx_byte),
      .o_Frame_Valid  (frame_valid),
      .i_Frame_Ack    (ack),
      .o_Frame_Cmd    (frame_cmd),
      .o_Frame_Len    (frame_len),
      .i_Rd_Addr      (rd_addr),
      .o_Rd_Data      (rd_data),
      .o_Err_Checksum (err_csum),
      .o_Err_Length   (err_len),
      .o_Err_Timeout  (err_tmo),
      .o_Err_Overrun  (err_ovr)
   );

   always @(negedge clk) begin
      if (err_csum) n_csum++;
      if (err_len)  n_len++;
      if (err_tmo)  n_tmo++;
      if (err_ovr)  n_ovr++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bytes(input bit b2b);
      while (tx_q.size() > 0) begin
         @(negedge clk);
         rx_dv   = 1'b1;
         rx_byte = tx_q.pop_front();
         if (!b2b) begin
            @(negedge clk);
            rx_dv = 1'b0;
         end
      end
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   // Frame per the format rules: checksum is the XOR of CMD, LEN and payload.
   task automatic build_frame(input logic [7:0] cmd, input int len, input logic [7:0] bad);
      logic [7:0] cs;
      cs = cmd ^ 8'(len);
      tx_q.push_back(8'hA5);
      tx_q.push_back(cmd);
      tx_q.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         tx_q.push_back(exp_pay[i]);
         cs ^= exp_pay[i];
      end
      tx_q.push_back(cs ^ bad);
   endtask

   task automatic read_byte(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      checks++;
      if ({frame_valid, frame_cmd, frame_len, rd_data, err_csum, err_len, err_tmo, err_ovr}
          !== 29'h0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b cmd=%h len=%h rd=%h errs=%b%b%b%b want all 0",
                  frame_valid, frame_cmd, frame_len, rd_data, err_csum, err_len, err_tmo, err_ovr);
      end
      exp_cmd = 8'h00;
      exp_len = 8'h00;
   endtask

   task automatic test_basic_frame(input bit b2b, input string nm);
      logic [7:0] d;
      logic [7:0] want [3];
      want = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) exp_pay[i] = want[i];
      build_frame(8'h10, 3, 8'h00);
      send_bytes(b2b);
      exp_cmd = 8'h10;
      exp_len = 8'h03;
      checks++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 8'h03) begin
         failures++;
         $display("FAIL %s_frame: got v=%b cmd=%h len=%h want v=1 cmd=10 len=03",
                  nm, frame_valid, frame_cmd, frame_len);
      end
      for (int i = 0; i < 3; i++) begin
         read_byte(8'(i), d);
         checks++;
         if (d !== want[i]) begin
            failures++;
            $display("FAIL %s_read[%0d]: got %h want %h", nm, i, d, want[i]);
         end
      end
      read_byte(8'd200, d);
      checks++;
      if (d !== 8'h00) begin
         failures++;
         $display("FAIL %s_read_oob: got %h want 00", nm, d);
      end
      do_ack();
      checks++;
      if (frame_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_ack: got valid=%b want 0", nm, frame_valid);
      end
   endtask

   task automatic test_checksum_error();
      int c0;
      c0 = n_csum;
      exp_pay[0] = 8'h11; exp_pay[1] = 8'h22; exp_pay[2] = 8'h33;
      build_frame(8'h10, 3, 8'h07);  // CSUM 14 instead of 13
      send_bytes(1'b0);
      idle(1);
      checks++;
      if (n_csum - c0 != 1 || frame_valid !== 1'b0) begin
         failures++;
         $display("FAIL csum_err: got pulses=%0d valid=%b want 1 and 0", n_csum - c0, frame_valid);
      end
      test_basic_frame(1'b0, "after_csum");
   endtask

   task automatic test_junk_zero_len();
      int c0, l0;
      c0 = n_csum;
      l0 = n_len;
      tx_q = '{8'h3C, 8'h00, 8'hA5, 8'h20, 8'h00, 8'h20};
      send_bytes(1'b0);
      exp_cmd = 8'h20;
      exp_len = 8'h00;
      checks++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h20 || frame_len !== 8'h00 ||
          n_csum != c0 || n_len != l0) begin
         failures++;
         $display("FAIL junk_zero_len: got v=%b cmd=%h len=%h errs=%0d want v=1 cmd=20 len=00 0",
                  frame_valid, frame_cmd, frame_len, (n_csum - c0) + (n_len - l0));
      end
      do_ack();
   endtask

   task automatic test_length_error();
      int l0;
      l0 = n_len;
      tx_q = '{8'hA5, 8'h10, 8'h11};
      send_bytes(1'b0);
      idle(1);
      checks++;
      if (n_len - l0 != 1 || frame_cmd !== exp_cmd || frame_len !== exp_len) begin
         failures++;
         $display("FAIL len_err: got pulses=%0d cmd=%h len=%h want 1 %h %h",
                  n_len - l0, frame_cmd, frame_len, exp_cmd, exp_len);
      end
      tx_q = '{8'hA5, 8'h21, 8'h00, 8'h21};
      send_bytes(1'b0);
      exp_cmd = 8'h21;
      exp_len = 8'h00;
      checks++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h21) begin
         failures++;
         $display("FAIL len_err_resync: got v=%b cmd=%h want 1 21", frame_valid, frame_cmd);
      end
      do_ack();
   endtask

   task automatic test_timeout();
      int t0;
      t0 = n_tmo;
      tx_q = '{8'hA5, 8'h10};
      send_bytes(1'b0);
`ifdef UART_FRAME_TIMEOUT_EN
      idle(TMO - 100);
      checks++;
      if (n_tmo != t0) begin
         failures++;
         $display("FAIL timeout_early: got pulses=%0d want 0", n_tmo - t0);
      end
      idle(200);
      checks++;
      if (n_tmo - t0 != 1) begin
         failures++;
         $display("FAIL timeout_pulse: got pulses=%0d want 1", n_tmo - t0);
      end
      test_basic_frame(1'b0, "after_tmo");
`else
      idle(300);
      checks++;
      if (n_tmo != t0 || err_tmo !== 1'b0) begin
         failures++;
         $display("FAIL timeout_off: got pulses=%0d want 0", n_tmo - t0);
      end
      tx_q = '{8'h01, 8'h5A, 8'h4B};  // LEN=1, payload 5A, CSUM 10^01^5A
      send_bytes(1'b0);
      exp_cmd = 8'h10;
      exp_len = 8'h01;
      checks++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 8'h01) begin
         failures++;
         $display("FAIL timeout_off_frame: got v=%b cmd=%h len=%h want 1 10 01",
                  frame_valid, frame_cmd, frame_len);
      end
      do_ack();
`endif
   endtask

   task automatic test_overrun();
      int o0, c0;
      logic [7:0] d;
      exp_pay[0] = 8'hDE; exp_pay[1] = 8'hAD;
      build_frame(8'h42, 2, 8'h00);
      send_bytes(1'b0);
      exp_cmd = 8'h42;
      exp_len = 8'h02;
      o0 = n_ovr;
      tx_q = '{8'h55};
      send_bytes(1'b0);
      idle(1);
      checks++;
      if (n_ovr - o0 != 1 || frame_valid !== 1'b1 || frame_cmd !== 8'h42 ||
          frame_len !== 8'h02) begin
         failures++;
         $display("FAIL overrun: got pulses=%0d v=%b cmd=%h len=%h want 1 1 42 02",
                  n_ovr - o0, frame_valid, frame_cmd, frame_len);
      end
      read_byte(8'd1, d);
      checks++;
      if (d !== 8'hAD) begin
         failures++;
         $display("FAIL overrun_payload: got %h want ad", d);
      end
      // Ack together with a SYNC byte: byte dropped, ack still honoured.
      o0 = n_ovr;
      c0 = n_csum;
      @(negedge clk);
      ack = 1'b1; rx_dv = 1'b1; rx_byte = 8'hA5;
      @(negedge clk);
      ack = 1'b0; rx_dv = 1'b0;
      tx_q = '{8'h20, 8'h00, 8'h20};
      send_bytes(1'b0);
      idle(1);
      checks++;
      if (n_ovr - o0 != 1 || frame_valid !== 1'b0 || n_csum != c0) begin
         failures++;
         $display("FAIL ack_with_dv: got ovr=%0d v=%b csum=%0d want 1 0 0",
                  n_ovr - o0, frame_valid, n_csum - c0);
      end
   endtask

   task automatic test_reset_mid_frame();
      tx_q = '{8'hA5, 8'h30, 8'h04, 8'h01, 8'h02};
      send_bytes(1'b0);
      test_reset();
      test_basic_frame(1'b0, "after_rst");
   endtask

   task automatic test_random(input int iters);
      logic [7:0] d, cmd, bad;
      int len, kind, c0, l0;
      for (int it = 0; it < iters; it++) begin
         kind = $urandom_range(0, 3);
         cmd  = 8'($urandom);
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            d = 8'($urandom);
            if (d == 8'hA5) d = 8'h5A;
            tx_q.push_back(d);
         end
         c0 = n_csum;
         l0 = n_len;
         if (kind == 3) begin
            len = $urandom_range(255, MAXP + 1);
            tx_q.push_back(8'hA5); tx_q.push_back(cmd); tx_q.push_back(8'(len));
            send_bytes(1'($urandom));
            idle(1);
            checks++;
            if (n_len - l0 != 1 || frame_valid !== 1'b0 || frame_cmd !== exp_cmd) begin
               failures++;
               $display("FAIL rand_len[%0d]: got pulses=%0d v=%b cmd=%h want 1 0 %h",
                        it, n_len - l0, frame_valid, frame_cmd, exp_cmd);
            end
         end else begin
            len = $urandom_range(0, MAXP);
            for (int i = 0; i < len; i++) exp_pay[i] = 8'($urandom);
            bad = (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(cmd, len, bad);
            send_bytes(1'($urandom));
            idle(1);
            if (bad != 8'h00) begin
               checks++;
               if (n_csum - c0 != 1 || frame_valid !== 1'b0 || frame_cmd !== exp_cmd ||
                   frame_len !== exp_len) begin
                  failures++;
                  $display("FAIL rand_csum[%0d]: got pulses=%0d v=%b cmd=%h len=%h want 1 0 %h %h",
                           it, n_csum - c0, frame_valid, frame_cmd, frame_len, exp_cmd, exp_len);
               end
            end else begin
               exp_cmd = cmd;
               exp_len = 8'(len);
               checks++;
               if (frame_valid !== 1'b1 || frame_cmd !== cmd || frame_len !== 8'(len)) begin
                  failures++;
                  $display("FAIL rand_frame[%0d]: got v=%b cmd=%h len=%h want 1 %h %h",
                           it, frame_valid, frame_cmd, frame_len, cmd, 8'(len));
               end
               for (int i = 0; i < len; i++) begin
                  read_byte(8'(i), d);
                  checks++;
                  if (d !== exp_pay[i]) begin
                     failures++;
                     $display("FAIL rand_read[%0d][%0d]: got %h want %h", it, i, d, exp_pay[i]);
                  end
               end
               do_ack();
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame(1'b0, "basic");
      test_checksum_error();
      test_junk_zero_len();
      test_length_error();
      test_timeout();
      test_overrun();
      test_reset_mid_frame();
      test_basic_frame(1'b1, "back_to_back");
      test_random(40);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-stream frame decoder directly downstream of the UART receiver: consumes its one-cycle byte-valid strobe and data byte, hunts for a sync byte, and parses command/length/payload/checksum frames into an internal payload buffer. A complete, checksum-valid frame is presented to the min-OS command logic with a level valid/ack handshake. The payload is read back through a registered random-access port.

## Interface
- `MAX_PAYLOAD`, 16: payload buffer depth in bytes, range 1..255.
- `TIMEOUT_CLKS`, 4160: inter-byte timeout in clocks; the default is 4 byte-times at 104 clks/bit.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `i_Clock`  in  1: single clock for all logic.
- `i_Reset`  in  1: synchronous, active-high reset.
- `i_Rx_DV`  in  1: one-cycle strobe from the UART receiver; `i_Rx_Byte` is valid when it is high.
- `i_Rx_Byte`  in  8: received byte.
- `o_Frame_Valid`  out  1: level signal; a complete frame is held for the consumer.
- `i_Frame_Ack`  in  1: consumer releases the held frame.
- `o_Frame_Cmd`  out  8: command byte of the held frame.
- `o_Frame_Len`  out  8: payload length of the held frame.
- `i_Rd_Addr`  in  8: payload read address.
- `o_Rd_Data`  out  8: payload byte, registered.
- `o_Err_Checksum`, `o_Err_Length`, `o_Err_Timeout`, `o_Err_Overrun`  out  1 each: one-cycle error pulses.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CSUM.
- CSUM is the XOR of CMD, LEN and all payload bytes.
- States and transitions:
  - S_SYNC: a byte equal to SYNC_BYTE moves to S_CMD. Any other byte is dropped silently, with no error.
  - S_CMD: latch the byte as CMD, seed the running XOR with it, go to S_LEN.
  - S_LEN: if LEN > MAX_PAYLOAD, pulse `o_Err_Length` and go to S_SYNC. If LEN = 0, go to S_CSUM. Otherwise clear the write index and go to S_PAYLOAD. In all cases XOR LEN into the checksum.
  - S_PAYLOAD: write the byte to buffer[index], XOR it into the checksum, increment the index. The byte at index LEN-1 moves to S_CSUM.
  - S_CSUM: if the byte equals the running XOR, go to S_HOLD with `o_Frame_Valid`=1. Otherwise pulse `o_Err_Checksum` and go to S_SYNC; `o_Frame_Valid` is not asserted.
  - S_HOLD: `o_Frame_Cmd`, `o_Frame_Len` and the buffer stay frozen. Every `i_Rx_DV` pulses `o_Err_Overrun` and the byte is discarded. `i_Frame_Ack` moves to S_SYNC.
- A bad frame never disturbs `o_Frame_Cmd`/`o_Frame_Len`. The buffer may hold partial data from the bad frame; the consumer may only read it under `o_Frame_Valid`.
- Read port: `o_Rd_Data` <= buffer[`i_Rd_Addr`] every cycle.
  - Addresses >= MAX_PAYLOAD return 8'h00.
  - Addresses >= LEN but < MAX_PAYLOAD return stale contents.
- Arithmetic:
  - The write index is `$clog2(MAX_PAYLOAD)` bits wide, minimum 1.
  - The length compare is done at 8 bits.
  - The timeout counter is `$clog2(TIMEOUT_CLKS+1)` bits wide.

## Timing
- Reset: state S_SYNC; all outputs 0, including `o_Rd_Data`, `o_Frame_Cmd` and `o_Frame_Len`. Buffer contents are not reset.
- Reset mid-frame aborts the frame with no error pulse.
- Latency:
  - `o_Frame_Valid` rises the cycle after the CSUM `i_Rx_DV`.
  - Error pulses occur in that same cycle after the offending strobe, one cycle wide.
- `i_Frame_Ack` is honoured only while `o_Frame_Valid`=1; `o_Frame_Valid` falls the next cycle. Ack outside S_HOLD is ignored.
- Ack and `i_Rx_DV` in the same cycle in S_HOLD: the byte is dropped with `o_Err_Overrun`, and the ack still takes effect.
- The next SYNC is accepted no earlier than the cycle after `o_Frame_Valid` falls.
- `o_Rd_Data` has a 1-cycle latency from `i_Rd_Addr`.
- The UART receiver guarantees at least 10 bit-times between strobes; the block still accepts back-to-back strobes on consecutive cycles.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - The timeout counter clears on every `i_Rx_DV` and counts in S_CMD, S_LEN, S_PAYLOAD and S_CSUM.
  - At count TIMEOUT_CLKS-1 without a strobe: pulse `o_Err_Timeout`, go to S_SYNC.
  - A strobe in the same cycle as expiry wins: the byte is processed and no timeout occurs.
- `UART_FRAME_TIMEOUT_EN` undefined: no counter is built, `o_Err_Timeout` is tied to 0, and a frame waits indefinitely.

## Structure
- Package `uart_frame_pkg`:
  - state enum (S_SYNC, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD);
  - default SYNC_BYTE constant;
  - default frame parameter constants.
- Sub-module `uart_frame_buf`: a MAX_PAYLOAD x 8 single-write, registered-read memory, so it maps to iCE40 BRAM or LUT RAM. The decoder FSM, checksum and timeout logic stay in `uart_frame_rx`.

## Test plan
- Bytes A5 10 03 11 22 33 13 → `o_Frame_Valid`=1, Cmd=10, Len=03; reads at addresses 0..2 return 11, 22, 33. Ack → valid=0 on the next cycle.
- Same frame with CSUM 14 → one `o_Err_Checksum` pulse, `o_Frame_Valid` stays 0. A following correct frame is then accepted.
- Bytes 3C 00 A5 20 00 20 → leading junk ignored silently; zero-length frame accepted with Cmd=20, Len=0.
- A5 10 11 (Len=17 with MAX_PAYLOAD=16) → `o_Err_Length`. The next byte A5 starts a new frame.
- With the macro defined: A5 10, then 4160 idle clocks → one `o_Err_Timeout` pulse. A full valid frame afterwards is accepted.
- Overrun and reset:
  - While a frame is held, send byte 55 → `o_Err_Overrun`; Cmd, Len and payload unchanged.
  - `i_Reset` mid-payload → all outputs 0; a subsequent frame decodes correctly.
